effect_xfade_router: RTL and testbench

Parametrised effect-output router for the pedal's DSP subsystem. Takes NUM_SRC effect outputs (clean, FIR, echo, drive, …) on the common sample clock and routes one to the DAC path. A selector change performs a linear crossfade over 2^FADE_LOG2 samples instead of a hard switch, which removes the audible click. The block also adds a registered selector, rejection of invalid selector codes, and status outputs.

---
 rtl/effect_xfade_router.sv | 166 ++++++++++++++++
 tb/tb_effect_xfade_router.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/effect_xfade_router.sv
// Effect-output router for the pedal DSP chain.
// Routes one of NUM_SRC effect outputs to the DAC path. A change of source is
// done as a linear crossfade over 2^FADE_LOG2 samples rather than a hard
// switch, so the change makes no click. Selector codes at or above NUM_SRC are
// ignored. fading and active_sel are registered in step with output_sample:
// each describes the sample that is on the output in the same cycle.
module effect_xfade_router #(
  parameter int WIDTH     = 16,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 3,
  parameter int FADE_LOG2 = 6
) (
  input  logic                     sample_clock,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         selector,
  input  logic [NUM_SRC*WIDTH-1:0] src_samples,
  output logic [WIDTH-1:0]         output_sample,
  output logic                     fading,
  output logic [SEL_W-1:0]         active_sel
);

  localparam int F     = FADE_LOG2;
  // Signed width of the weighted sum: a WIDTH-bit sample times a weight of at
  // most 2^F, plus one bit of headroom for the addition.
  localparam int SUM_W = WIDTH + F + 1;

  localparam logic [SEL_W:0] NUM_SRC_L   = (SEL_W + 1)'(NUM_SRC);
  localparam logic [F-1:0]   CNT_LAST    = '1;
  localparam logic [F-1:0]   CNT_ONE     = F'(1);
  localparam logic [F:0]     FULL_WEIGHT = {1'b1, {F{1'b0}}};

  // Parameter sanity, caught at elaboration.
  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("effect_xfade_router: NUM_SRC must be at least 2");
  end
  if ((1 << SEL_W) < NUM_SRC) begin : g_bad_sel_w
    $error("effect_xfade_router: SEL_W too narrow for NUM_SRC");
  end
  if (FADE_LOG2 < 1) begin : g_bad_fade
    $error("effect_xfade_router: FADE_LOG2 must be at least 1");
  end

  typedef enum logic {
    ST_STEADY = 1'b0,
    ST_FADE   = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [SEL_W-1:0]        sel_q_reg;
  logic [SEL_W-1:0]        cur_reg;
  logic [SEL_W-1:0]        nxt_reg;
  logic [F-1:0]            cnt_reg;
  logic [WIDTH-1:0]        out_reg;
  logic                    fading_reg;
  logic [SEL_W-1:0]        active_reg;

  logic signed [WIDTH-1:0] src_slot [NUM_SRC];
  logic signed [WIDTH-1:0] cur_sample;
  logic signed [WIDTH-1:0] nxt_sample;
  logic                    sel_valid;

  logic [F:0]              w_nxt;
  logic [F:0]              w_cur;
  logic signed [SUM_W-1:0] cur_ext;
  logic signed [SUM_W-1:0] nxt_ext;
  logic signed [SUM_W-1:0] w_cur_ext;
  logic signed [SUM_W-1:0] w_nxt_ext;
  logic signed [SUM_W-1:0] prod_cur;
  logic signed [SUM_W-1:0] prod_nxt;
  logic signed [SUM_W-1:0] mix_sum;
  logic signed [WIDTH-1:0] mix_sample;
  logic                    unused_mix_bits;

  // Unpack the source bus into one signed sample per slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      assign src_slot[gi] = src_samples[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Source multiplexers for the settled and the target slot.
  always_comb begin
    cur_sample = '0;
    nxt_sample = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cur_reg == SEL_W'(k)) begin
        cur_sample = src_slot[k];
      end
      if (nxt_reg == SEL_W'(k)) begin
        nxt_sample = src_slot[k];
      end
    end
  end

  // A registered code is only acted on when it names an existing slot.
  assign sel_valid = ({1'b0, sel_q_reg} < NUM_SRC_L);

  // Crossfade weights: the target gets cnt/2^F, the outgoing source the rest.
  assign w_nxt = {1'b0, cnt_reg};
  assign w_cur = FULL_WEIGHT - w_nxt;

  // Sign-extend the samples, zero-extend the weights, then do a signed
  // multiply-accumulate at full width. The weights sum to 2^F, so the result
  // is a convex combination and always fits back into WIDTH bits.
  assign cur_ext   = {{(F + 1){cur_sample[WIDTH-1]}}, cur_sample};
  assign nxt_ext   = {{(F + 1){nxt_sample[WIDTH-1]}}, nxt_sample};
  assign w_cur_ext = {{WIDTH{1'b0}}, w_cur};
  assign w_nxt_ext = {{WIDTH{1'b0}}, w_nxt};
  assign prod_cur  = cur_ext * w_cur_ext;
  assign prod_nxt  = nxt_ext * w_nxt_ext;
  assign mix_sum   = prod_cur + prod_nxt;

  // Arithmetic shift right by F (floor rounding), taken as a bit slice; the
  // discarded sign bit is redundant because the mix cannot overflow.
  assign mix_sample      = mix_sum[F +: WIDTH];
  assign unused_mix_bits = ^{mix_sum[SUM_W-1], mix_sum[F-1:0]};

  // Routing state machine with registered sample and status outputs.
  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_STEADY;
      sel_q_reg  <= '0;
      cur_reg    <= '0;
      nxt_reg    <= '0;
      cnt_reg    <= '0;
      out_reg    <= '0;
      fading_reg <= 1'b0;
      active_reg <= '0;
    end else begin
      sel_q_reg <= selector;
      case (state_reg)
        ST_STEADY: begin
          out_reg    <= cur_sample;
          fading_reg <= 1'b0;
          active_reg <= cur_reg;
          if (sel_valid && (sel_q_reg != cur_reg)) begin
            nxt_reg   <= sel_q_reg;
            cnt_reg   <= '0;
            state_reg <= ST_FADE;
          end
        end
        ST_FADE: begin
          // Selector changes are not looked at here; the fade always runs
          // to completion and STEADY re-evaluates afterwards.
          out_reg    <= mix_sample;
          fading_reg <= 1'b1;
          active_reg <= cur_reg;
          cnt_reg    <= cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) begin
            cur_reg   <= nxt_reg;
            state_reg <= ST_STEADY;
          end
        end
        default: begin
          state_reg <= ST_STEADY;
        end
      endcase
    end
  end

  assign output_sample = out_reg;
  assign fading        = fading_reg;
  assign active_sel    = active_reg;

endmodule

// File: tb/tb_effect_xfade_router.sv
// Directed bench for effect_xfade_router (WIDTH=16, NUM_SRC=3, FADE_LOG2=2).
// A vector table covers reset release, routing, crossfades, floor rounding and
// full-scale extremes; hand-written sequences cover a selector change during a
// fade, an invalid selector code and reset asserted mid-fade.
module tb_effect_xfade_router;

  localparam int WIDTH     = 16;
  localparam int NUM_SRC   = 3;
  localparam int SEL_W     = 2;
  localparam int FADE_LOG2 = 2;

  logic                     sample_clock;
  logic                     reset;
  logic [SEL_W-1:0]         selector;
  logic signed [WIDTH-1:0]  s0;
  logic signed [WIDTH-1:0]  s1;
  logic signed [WIDTH-1:0]  s2;
  logic [NUM_SRC*WIDTH-1:0] src_samples;
  logic [WIDTH-1:0]         output_sample;
  logic                     fading;
  logic [SEL_W-1:0]         active_sel;

  assign src_samples = {s2, s1, s0};

  effect_xfade_router #(
    .WIDTH    (WIDTH),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .FADE_LOG2(FADE_LOG2)
  ) dut (
    .sample_clock (sample_clock),
    .reset        (reset),
    .selector     (selector),
    .src_samples  (src_samples),
    .output_sample(output_sample),
    .fading       (fading),
    .active_sel   (active_sel)
  );

  initial begin
    sample_clock = 1'b0;
    forever #5 sample_clock = ~sample_clock;
  end

  typedef struct {
    int sel;
    int s0;
    int s1;
    int exp_out;
    int exp_fad;
    int exp_act;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add_vec(int sel, int v0, int v1, int e_out, int e_fad, int e_act);
    vec_t v;
    v.sel     = sel;
    v.s0      = v0;
    v.s1      = v1;
    v.exp_out = e_out;
    v.exp_fad = e_fad;
    v.exp_act = e_act;
    vecs.push_back(v);
  endfunction

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(string name, int e_out, int e_fad, int e_act);
    int out_v;
    out_v = int'($signed(output_sample));
    $display("txn %s out=%0d fading=%0d active_sel=%0d", name, out_v, fading, active_sel);
    check_val({name, ".out"}, out_v, e_out);
    check_val({name, ".fading"}, int'(fading), e_fad);
    check_val({name, ".active_sel"}, int'(active_sel), e_act);
  endtask

  // Advance one sample and settle just after the edge.
  task automatic step();
    @(posedge sample_clock);
    #1;
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Crossfade 0->1 with 1000 / -1000.
    add_vec(0, 1000, -1000, 1000, 0, 0);
    add_vec(1, 1000, -1000, 1000, 0, 0);
    add_vec(1, 1000, -1000, 1000, 0, 0);
    add_vec(1, 1000, -1000, 1000, 1, 0);
    add_vec(1, 1000, -1000, 500, 1, 0);
    add_vec(1, 1000, -1000, 0, 1, 0);
    add_vec(1, 1000, -1000, -500, 1, 0);
    add_vec(1, 1000, -1000, -1000, 0, 1);
    // Back to 0 with src0=-1, src1=0.
    add_vec(0, -1, 0, 0, 0, 1);
    add_vec(0, -1, 0, 0, 0, 1);
    add_vec(0, -1, 0, 0, 1, 1);
    add_vec(0, -1, 0, -1, 1, 1);
    add_vec(0, -1, 0, -1, 1, 1);
    add_vec(0, -1, 0, -1, 1, 1);
    add_vec(0, -1, 0, -1, 0, 0);
    // Rounding: 0->1 from -1 to 0, every mix floors to -1.
    add_vec(1, -1, 0, -1, 0, 0);
    add_vec(1, -1, 0, -1, 0, 0);
    add_vec(1, -1, 0, -1, 1, 0);
    add_vec(1, -1, 0, -1, 1, 0);
    add_vec(1, -1, 0, -1, 1, 0);
    add_vec(1, -1, 0, -1, 1, 0);
    add_vec(1, -1, 0, 0, 0, 1);
    // Extremes: 1->0 from 32767 to -32768.
    add_vec(0, -32768, 32767, 32767, 0, 1);
    add_vec(0, -32768, 32767, 32767, 0, 1);
    add_vec(0, -32768, 32767, 32767, 1, 1);
    add_vec(0, -32768, 32767, 16383, 1, 1);
    add_vec(0, -32768, 32767, -1, 1, 1);
    add_vec(0, -32768, 32767, -16385, 1, 1);
    add_vec(0, -32768, 32767, -32768, 0, 0);
    // Extremes: 0->1 from -32768 to 32767.
    add_vec(1, -32768, 32767, -32768, 0, 0);
    add_vec(1, -32768, 32767, -32768, 0, 0);
    add_vec(1, -32768, 32767, -32768, 1, 0);
    add_vec(1, -32768, 32767, -16385, 1, 0);
    add_vec(1, -32768, 32767, -1, 1, 0);
    add_vec(1, -32768, 32767, 16383, 1, 0);
    add_vec(1, -32768, 32767, 32767, 0, 1);

    // Reset: asynchronous assertion, outputs held at zero through edges.
    reset    = 1'b1;
    selector = '0;
    s0 = '0;
    s1 = '0;
    s2 = '0;
    #1 reset = 1'b0;
    #1 check_all("reset_async", 0, 0, 0);
    s0 = 16'(1000);
    s1 = 16'(-1000);
    s2 = 16'(2000);
    repeat (2) begin
      step();
      check_all("reset_hold", 0, 0, 0);
    end
    reset = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      selector = SEL_W'(vecs[i].sel);
      s0       = 16'(vecs[i].s0);
      s1       = 16'(vecs[i].s1);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_fad, vecs[i].exp_act);
    end

    // Selector change to 2 during a 0->1 fade (at cnt=1).
    selector = 2'd0;
    s0 = 16'(0);
    s1 = 16'(400);
    s2 = 16'(800);
    repeat (8) step();
    check_all("mid_settle0", 0, 0, 0);
    selector = 2'd1;
    step(); check_all("mid_t0", 0, 0, 0);
    step(); check_all("mid_t1", 0, 0, 0);
    step(); check_all("mid_c0", 0, 1, 0);
    selector = 2'd2;
    step(); check_all("mid_c1", 100, 1, 0);
    step(); check_all("mid_c2", 200, 1, 0);
    step(); check_all("mid_c3", 300, 1, 0);
    step(); check_all("mid_gap", 400, 0, 1);
    step(); check_all("mid_b_c0", 400, 1, 1);
    step(); check_all("mid_b_c1", 500, 1, 1);
    step(); check_all("mid_b_c2", 600, 1, 1);
    step(); check_all("mid_b_c3", 700, 1, 1);
    step(); check_all("mid_done", 800, 0, 2);

    // Invalid code 3 held for 20 cycles; source 2 keeps being routed live.
    selector = 2'd3;
    for (int i = 0; i < 20; i++) begin
      s2 = 16'(i * 37 - 300);
      step();
      check_all($sformatf("invalid%0d", i), i * 37 - 300, 0, 2);
    end

    // Reset asserted at cnt=2 of a 0->1 fade.
    selector = 2'd0;
    s0 = 16'(100);
    s1 = 16'(900);
    repeat (8) step();
    check_all("rst_settle0", 100, 0, 0);
    selector = 2'd1;
    step();
    step();
    step(); check_all("rst_c0", 100, 1, 0);
    step(); check_all("rst_c1", 300, 1, 0);
    #2 reset = 1'b0;
    #1 check_all("rst_async_mid", 0, 0, 0);
    selector = 2'd0;
    step(); check_all("rst_mid_hold", 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_all($sformatf("rst_after%0d", i), 100, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
